// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the control-board serial link
// (transmitter and receiver).
package serial_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLK_PER_BIT-1 and pulses tick_o on the last clock
// of each bit period. clear_i holds the count at zero.
module serial_bit_timer #(
    parameter  int CLK_PER_BIT = 50,
    localparam int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    logic [CTR_SIZE-1:0] cnt_q;
    logic [CTR_SIZE-1:0] cnt_d;

    assign tick_o = (cnt_q == CTR_SIZE'(CLK_PER_BIT - 1));

    // Next count: wrap at the end of a bit period so the wrap and the bit advance share an edge
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CTR_SIZE'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter with a one-byte holding register so that back-to-back
// frames leave no idle gap; `block` holds off new frames for flow control.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       new_data,
    input  logic       block,
    output logic       tx,
    output logic       busy
);

    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic                 tx_q;

    logic tick_s;
    logic clear_s;
    logic load_s;
    logic accept_s;

    assign tx   = tx_q;
    assign busy = hold_full_q;

    serial_bit_timer #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(clear_s),
        .tick_o (tick_s)
    );

    // Frame-start decision: block is only consulted in IDLE and at the end of the stop bit
    always_comb begin
        clear_s  = (state_q == TX_IDLE);
        accept_s = new_data && !hold_full_q;
        if (hold_full_q && !block) begin
            load_s = (state_q == TX_IDLE) || ((state_q == TX_STOP) && tick_s);
        end else begin
            load_s = 1'b0;
        end
    end

    // FSM, shift register, holding register and registered line output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            // tx trails the state by one clock
            case (state_q)
                TX_START: tx_q <= 1'b0;
                TX_DATA:  tx_q <= shift_q[0];
                default:  tx_q <= 1'b1;
            endcase

            // A transfer needs a full holder and an accept needs an empty one, so they never collide
            if (load_s) begin
                hold_full_q <= 1'b0;
            end else if (accept_s) begin
                hold_q      <= data;
                hold_full_q <= 1'b1;
            end

            case (state_q)
                TX_IDLE: begin
                    if (load_s) begin
                        shift_q   <= hold_q;
                        bit_idx_q <= '0;
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick_s) begin
                        bit_idx_q <= '0;
                        state_q   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tick_s) begin
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
                            state_q   <= TX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tick_s) begin
                        if (load_s) begin
                            shift_q   <= hold_q;
                            bit_idx_q <= '0;
                            state_q   <= TX_START;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a frame-schedule model predicts tx and busy
// after every clock edge and the DUT is compared against it cycle by cycle.
module tb_serial_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       new_data;
    logic       block;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    serial_tx #(
        .CLK_PER_BIT(CPB)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .new_data(new_data),
        .block   (block),
        .tx      (tx),
        .busy    (busy)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model: one pending byte, plus the currently scheduled frame.
    // A frame transferred at edge T drives tx after edges T+1 .. T+10*CPB;
    // the next frame-start decision is allowed from edge T+10*CPB onwards.
    bit         m_hold_v  = 1'b0;
    logic [7:0] m_hold    = 8'h00;
    bit         m_frame_v = 1'b0;
    logic [7:0] m_fbyte   = 8'h00;
    int         m_t       = 0;
    int         m_next    = 0;
    logic       exp_tx;
    logic       exp_busy;

    task automatic step();
        logic [9:0] frame;
        int         k;
        bit         hold_before;
        @(posedge clk);
        cyc++;
        if (rst_n !== 1'b1) begin
            m_hold_v  = 1'b0;
            m_frame_v = 1'b0;
            m_next    = cyc + 1;
            exp_tx    = 1'b1;
        end else begin
            exp_tx = 1'b1;
            if (m_frame_v && (cyc >= m_t + 1) && (cyc <= m_t + 10 * CPB)) begin
                frame  = {1'b1, m_fbyte, 1'b0};
                k      = (cyc - m_t - 1) / CPB;
                exp_tx = frame[k];
            end
            hold_before = m_hold_v;
            if ((cyc >= m_next) && hold_before && (block === 1'b0)) begin
                m_frame_v = 1'b1;
                m_fbyte   = m_hold;
                m_t       = cyc;
                m_next    = cyc + 10 * CPB;
                m_hold_v  = 1'b0;
            end
            if ((new_data === 1'b1) && !hold_before) begin
                m_hold   = data;
                m_hold_v = 1'b1;
            end
        end
        exp_busy = m_hold_v;
        #1;
        n_vec++;
        assert (tx === exp_tx) else begin
            n_miss++;
            $error("FAIL tx cycle %0d observed=%b expected=%b", cyc, tx, exp_tx);
        end
        assert (busy === exp_busy) else begin
            n_miss++;
            $error("FAIL busy cycle %0d observed=%b expected=%b", cyc, busy, exp_busy);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    // One-cycle strobe; data is scrambled afterwards to show it is not re-sampled
    task automatic strobe(input logic [7:0] b);
        data     = b;
        new_data = 1'b1;
        step();
        new_data = 1'b0;
        data     = 8'($urandom);
    endtask

    task automatic wait_hold_empty();
        for (int i = 0; i < 20 * CPB && m_hold_v; i++) begin
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        new_data = 1'b0;
        block    = 1'b0;
        data     = 8'h00;

        // Reset and quiet line
        run(3);
        rst_n = 1'b1;
        run(50);

        // Single byte 0x55
        strobe(8'h55);
        run(10 * CPB + 5);

        // Back-to-back 0xA5 then 0x3C as soon as the holder empties
        strobe(8'hA5);
        wait_hold_empty();
        strobe(8'h3C);
        run(20 * CPB + 5);

        // Overrun: 0x33 arrives while 0x22 is held and is dropped
        strobe(8'h11);
        wait_hold_empty();
        strobe(8'h22);
        strobe(8'h33);
        run(30 * CPB + 5);

        // Flow control while idle
        block = 1'b1;
        strobe(8'h7E);
        run(20);
        block = 1'b0;
        run(10 * CPB + 5);

        // Block raised mid-frame does not alter the frame
        strobe(8'($urandom));
        run(3 * CPB);
        block = 1'b1;
        run(10 * CPB);
        block = 1'b0;
        run(5);

        // Reset during data bit 3 with a byte queued, then 0xC3
        strobe(8'h96);
        wait_hold_empty();
        strobe(8'h5A);
        run(4 * CPB);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(5);
        strobe(8'hC3);
        run(10 * CPB + 5);

        // Random traffic with occasional block and reset
        for (int i = 0; i < 1500; i++) begin
            new_data = ($urandom_range(0, 3) == 0);
            data     = 8'($urandom);
            block    = ($urandom_range(0, 9) == 0);
            rst_n    = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n    = 1'b1;
        new_data = 1'b0;
        block    = 1'b0;
        run(20 * CPB + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

UART transmitter for the control-board serial link. It serialises bytes as 8N1 frames: one start bit (0), eight data bits LSB first, and one stop bit (1). Each bit lasts CLK_PER_BIT clocks. The block sits between the command/response logic and the board TX pin, and is the counterpart of the existing serial receiver. A one-byte holding register lets the next byte be queued during a frame, so back-to-back frames leave no idle gap. A `block` input holds off new frames for flow control.

## Interface
- CLK_PER_BIT, default 50: clocks per bit period; must be ≥ 2.
- CTR_SIZE, default $clog2(CLK_PER_BIT): width of the bit-period counter; derived, not overridden.

- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- data  in  8  byte to send; sampled only when `new_data` is accepted.
- new_data  in  1  single-cycle load strobe; accepted iff `busy`=0 in the same cycle.
- block  in  1  when 1, no new frame may start; a frame already in progress completes.
- tx  out  1  serial line, registered; idles at 1.
- busy  out  1  holding register full (1 = `new_data` would be dropped), registered.

## Operation
- Reset values: `tx`=1, `busy`=0, state IDLE, bit counter 0, data-bit index 0, holding register empty.
- Holding register (hold_q, hold_full):
  - `new_data`=1 with `busy`=0 loads `data` into hold_q and sets hold_full.
  - `new_data`=1 with `busy`=1 is ignored; the byte is dropped and there is no error flag.
  - `busy` = hold_full.
  - Changes on `data` after acceptance have no effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If hold_full and `block`=0, move hold_q into the shift register, clear hold_full, reset the counter, go to START.
  - START: `tx`=0 for CLK_PER_BIT clocks, then go to DATA with index 0.
  - DATA: `tx`=shift[0] for CLK_PER_BIT clocks, then shift right and increment the index. After the 8th bit (index 7 done), go to STOP.
  - STOP: `tx`=1 for CLK_PER_BIT clocks. At the end:
    - if hold_full and `block`=0, load as in IDLE and go straight to START (no idle clock);
    - otherwise go to IDLE.
- Counter: counts 0..CLK_PER_BIT-1 and wraps to 0 at each bit boundary. The wrap and the state/bit advance happen on the same edge.
- A new byte may be accepted in any state, including mid-frame, provided hold_full=0.
- Simultaneous events:
  - A hold→shift transfer and a `new_data` on the same edge: `busy` was 0 that cycle only if the holding register was already empty, so no transfer is pending and there is no conflict.
  - If the transfer empties hold on edge N, `busy` drops after edge N and a strobe in the following cycle is accepted.
- `block` is sampled only at frame-start decisions (in IDLE every cycle, and at the end of STOP). Asserting it mid-frame does not shorten or stretch the frame.
- Reset mid-frame: the next edge with `rst_n`=0 forces `tx`=1, `busy`=0 and state IDLE. The partial frame is abandoned and the queued byte discarded.

## Timing
- Accept latency: `new_data` sampled at edge 0 (IDLE, empty) → `busy`=1 after edge 0 → transfer at edge 1 (`busy`=0, state START) → `tx`=0 after edge 2, since `tx` is registered one stage behind the state.
- Frame length: exactly 10·CLK_PER_BIT clocks from the `tx` fall to the end of the stop bit.
- Back-to-back: the next start bit immediately follows the stop bit, giving a period of 10·CLK_PER_BIT per byte.
- Throughput: one byte per frame.

## Structure
- Shared package serial_pkg holds:
  - state encoding localparams TX_IDLE/TX_START/TX_DATA/TX_STOP (2 bits);
  - the frame constants DATA_BITS=8 and FRAME_BITS=10, shared with the receiver.
- One natural sub-module, serial_bit_timer (CLK_PER_BIT): provides a counter with `clear` and a `tick` output at the end of each bit period. It is reusable by the receiver.
- Everything else stays in serial_tx: FSM, shift register, holding register.

## Test plan
- Reset: hold `rst_n`=0 for 3 clocks → `tx`=1 and `busy`=0; no activity for 50 clocks afterwards.
- Single byte, CLK_PER_BIT=4, `data`=0x55 → `tx` gives bits 0,1,0,1,0,1,0,1,0,1, each exactly 4 clocks; frame spans 40 clocks; `tx`=1 afterwards.
- Back-to-back: strobe 0xA5, then strobe 0x3C as soon as `busy`=0 → 20 bit periods with no idle clock; decoded bytes are 0xA5 then 0x3C.
- Overrun: strobe 0x11 (goes to shift), 0x22 (held), then 0x33 while `busy`=1 → only 0x11 and 0x22 are transmitted.
- Flow control: `block`=1, strobe 0x7E → `tx` stays 1 and `busy` stays 1. Release `block` → start bit follows two clocks later. Separately, raise `block` mid-frame → the current frame completes unchanged.
- Reset mid-frame during DATA bit 3 → `tx`=1 on the next edge, queued byte lost, and a subsequent 0xC3 is transmitted correctly. Finally, looping `tx` into serial_rx at CLK_PER_BIT=50 with 256 random bytes → every byte is received intact.
